// File: rtl/vertex_transform_pkg.sv
// Shared types, fixed-point constants and helpers for the vertex transform block.
// Q16.16 signed fixed point is used for vertices and matrix entries alike.
package vertex_pkg;

  localparam int FRAC_BITS = 16;
  localparam int PIPE_LAT  = 3;

  typedef logic signed [31:0] fixed_t;
  typedef fixed_t [3:0]  vec4_t;   // [3]=x [2]=y [1]=z [0]=w
  typedef fixed_t [15:0] mat_t;    // index row*4+col, row 0 produces x

  localparam fixed_t FIXED_ONE = 32'h0001_0000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE1 = 2'd1,
    ST_ISSUE2 = 2'd2,
    ST_ISSUE3 = 2'd3
  } state_t;

  function automatic mat_t identity_mat();
    mat_t m;
    m = '0;
    for (int i = 0; i < 4; i++) m[i*5] = FIXED_ONE;
    return m;
  endfunction

  localparam mat_t MAT_IDENTITY = identity_mat();

  function automatic logic signed [63:0] mul_fx(input fixed_t a, input fixed_t b);
    logic signed [63:0] ea;
    logic signed [63:0] eb;
    ea = 64'(a);
    eb = 64'(b);
    return ea * eb;
  endfunction

  // Clamp a wide signed value into the 32-bit range.
  function automatic fixed_t sat_fx(input logic signed [65:0] v);
    fixed_t r;
    if (v[65:31] == {35{v[65]}}) r = v[31:0];
    else if (v[65])              r = 32'h8000_0000;
    else                         r = 32'h7FFF_FFFF;
    return r;
  endfunction

endpackage

// File: rtl/vertex_transform_if.sv
// Triangle input, matrix write port and transformed triangle output bundle.
// Handshake: valid_in/valid_out are single-cycle pulses with no back-pressure; data is qualified only by its pulse.
interface vertex_transform_if
  import vertex_pkg::*;
();

  vec4_t       v1_in;
  vec4_t       v2_in;
  vec4_t       v3_in;
  logic        valid_in;
  logic        obj_done_in;
  logic        mat_we;
  logic [3:0]  mat_addr;
  fixed_t      mat_data;
  logic        mat_commit;

  vec4_t       v1_out;
  vec4_t       v2_out;
  vec4_t       v3_out;
  logic        valid_out;
  logic        obj_done_out;
  logic        mat_pending;
  logic        overflow;
  state_t      dbg_state;

  modport master (
    output v1_in, v2_in, v3_in, valid_in, obj_done_in,
    output mat_we, mat_addr, mat_data, mat_commit,
    input  v1_out, v2_out, v3_out, valid_out, obj_done_out,
    input  mat_pending, overflow, dbg_state
  );

  modport slave (
    input  v1_in, v2_in, v3_in, valid_in, obj_done_in,
    input  mat_we, mat_addr, mat_data, mat_commit,
    output v1_out, v2_out, v3_out, valid_out, obj_done_out,
    output mat_pending, overflow, dbg_state
  );

endinterface

// File: rtl/vertex_transform_mat_vec_pipe.sv
// Three-stage 4x4 matrix times vec4: products, row sums, shift+saturate.
// A 2-bit tag rides alongside each vector so the consumer knows which vertex emerges.
module mat_vec_pipe
  import vertex_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [1:0] in_tag,
  input  mat_t       mat,
  input  vec4_t      vec,
  output logic       out_valid,
  output logic [1:0] out_tag,
  output vec4_t      out_vec,
  output logic       busy
);

  logic signed [63:0] prod_d [16];
  logic signed [63:0] prod_q [16];
  logic signed [65:0] sum_d  [4];
  logic signed [65:0] sum_q  [4];
  vec4_t              res_d, res_q;
  logic [PIPE_LAT-1:0]       vld_d, vld_q;
  logic [PIPE_LAT-1:0][1:0]  tag_d, tag_q;

  always_comb begin
    for (int r = 0; r < 4; r++) begin
      // column c multiplies vector component x,y,z,w, stored at [3-c]
      for (int c = 0; c < 4; c++) prod_d[r*4+c] = mul_fx(mat[r*4+c], vec[3-c]);
      sum_d[r] = 66'(prod_q[r*4])   + 66'(prod_q[r*4+1]) +
                 66'(prod_q[r*4+2]) + 66'(prod_q[r*4+3]);
      res_d[3-r] = sat_fx(sum_q[r] >>> FRAC_BITS);
    end
    vld_d = {vld_q[PIPE_LAT-2:0], in_valid};
    tag_d = {tag_q[PIPE_LAT-2:0], in_tag};
  end

  always_ff @(posedge clk) begin
    prod_q <= prod_d;
    sum_q  <= sum_d;
    res_q  <= res_d;
    if (rst) begin
      vld_q <= '0;
      tag_q <= '0;
    end else begin
      vld_q <= vld_d;
      tag_q <= tag_d;
    end
  end

  assign out_valid = vld_q[PIPE_LAT-1];
  assign out_tag   = tag_q[PIPE_LAT-1];
  assign out_vec   = res_q;
  assign busy      = |vld_q;

endmodule

// File: rtl/vertex_transform.sv
// Captures a triangle, streams its three vertices through the shared matrix pipe
// and reassembles them; the matrix is double-buffered and swapped only between objects.
module vertex_transform
  import vertex_pkg::*;
(
  input logic               clk_in,
  input logic               rst_in,
  vertex_transform_if.slave bus
);

  state_t state_q, state_d;
  vec4_t  cap1_q, cap1_d, cap2_q, cap2_d, cap3_q, cap3_d;
  logic   done_cap_q, done_cap_d, done_fly_q, done_fly_d;
  mat_t   act_q, act_d, shd_q, shd_d;
  logic   pending_q, pending_d, partial_q, partial_d, overflow_q, overflow_d;
  vec4_t  hold1_q, hold1_d, hold2_q, hold2_d;
  vec4_t  out1_q, out1_d, out2_q, out2_d, out3_q, out3_d;

  logic       accept, copy, tri_valid;
  logic       issue_valid;
  logic [1:0] issue_tag;
  vec4_t      issue_vec;
  logic       pipe_valid, pipe_busy;
  logic [1:0] pipe_tag;
  vec4_t      pipe_vec;
  logic       unused_w;

  assign unused_w = ^{bus.v1_in[0], bus.v2_in[0], bus.v3_in[0]};

  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    issue_valid = 1'b0;
    issue_tag   = 2'd0;
    issue_vec   = cap1_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.valid_in) begin
          accept  = 1'b1;
          state_d = ST_ISSUE1;
        end
      end
      ST_ISSUE1: begin
        issue_valid = 1'b1;
        issue_tag   = 2'd1;
        issue_vec   = cap1_q;
        state_d     = ST_ISSUE2;
      end
      ST_ISSUE2: begin
        issue_valid = 1'b1;
        issue_tag   = 2'd2;
        issue_vec   = cap2_q;
        state_d     = ST_ISSUE3;
      end
      ST_ISSUE3: begin
        issue_valid = 1'b1;
        issue_tag   = 2'd3;
        issue_vec   = cap3_q;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cap1_d     = accept ? {bus.v1_in[3:1], FIXED_ONE} : cap1_q;
    cap2_d     = accept ? {bus.v2_in[3:1], FIXED_ONE} : cap2_q;
    cap3_d     = accept ? {bus.v3_in[3:1], FIXED_ONE} : cap3_q;
    done_cap_d = accept ? bus.obj_done_in : done_cap_q;
    // The previous triangle's flag must survive until its vertex 3 leaves the pipe.
    done_fly_d = (state_q == ST_ISSUE3) ? done_cap_q : done_fly_q;
    partial_d  = accept ? ~bus.obj_done_in : partial_q;
    overflow_d = overflow_q | (bus.valid_in & (state_q != ST_IDLE));

    shd_d = shd_q;
    if (bus.mat_we) shd_d[bus.mat_addr] = bus.mat_data;
    copy  = pending_q & (state_q == ST_IDLE) & ~pipe_busy & ~partial_q;
    act_d = copy ? shd_d : act_q;
    pending_d = bus.mat_commit ? 1'b1 : (copy ? 1'b0 : pending_q);

    tri_valid = pipe_valid & (pipe_tag == 2'd3);
    hold1_d   = (pipe_valid & (pipe_tag == 2'd1)) ? pipe_vec : hold1_q;
    hold2_d   = (pipe_valid & (pipe_tag == 2'd2)) ? pipe_vec : hold2_q;
    out1_d    = tri_valid ? hold1_q  : out1_q;
    out2_d    = tri_valid ? hold2_q  : out2_q;
    out3_d    = tri_valid ? pipe_vec : out3_q;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= ST_IDLE;
      cap1_q     <= '0;
      cap2_q     <= '0;
      cap3_q     <= '0;
      done_cap_q <= 1'b0;
      done_fly_q <= 1'b0;
      act_q      <= MAT_IDENTITY;
      shd_q      <= MAT_IDENTITY;
      pending_q  <= 1'b0;
      partial_q  <= 1'b0;
      overflow_q <= 1'b0;
      hold1_q    <= '0;
      hold2_q    <= '0;
      out1_q     <= '0;
      out2_q     <= '0;
      out3_q     <= '0;
    end else begin
      state_q    <= state_d;
      cap1_q     <= cap1_d;
      cap2_q     <= cap2_d;
      cap3_q     <= cap3_d;
      done_cap_q <= done_cap_d;
      done_fly_q <= done_fly_d;
      act_q      <= act_d;
      shd_q      <= shd_d;
      pending_q  <= pending_d;
      partial_q  <= partial_d;
      overflow_q <= overflow_d;
      hold1_q    <= hold1_d;
      hold2_q    <= hold2_d;
      out1_q     <= out1_d;
      out2_q     <= out2_d;
      out3_q     <= out3_d;
    end
  end

  mat_vec_pipe u_pipe (
    .clk       (clk_in),
    .rst       (rst_in),
    .in_valid  (issue_valid),
    .in_tag    (issue_tag),
    .mat       (act_q),
    .vec       (issue_vec),
    .out_valid (pipe_valid),
    .out_tag   (pipe_tag),
    .out_vec   (pipe_vec),
    .busy      (pipe_busy)
  );

  // Vertex 3 is forwarded straight from the pipe so the whole triangle appears with valid_out.
  assign bus.v1_out       = out1_d;
  assign bus.v2_out       = out2_d;
  assign bus.v3_out       = out3_d;
  assign bus.valid_out    = tri_valid;
  assign bus.obj_done_out = tri_valid & done_fly_q;
  assign bus.mat_pending  = pending_q;
  assign bus.overflow     = overflow_q;
  assign bus.dbg_state    = state_q;

endmodule

// File: tb/tb_vertex_transform.sv
// Randomized and directed stimulus for vertex_transform, checked by a queue-based
// scoreboard against a cycle-count reference model of acceptance, commit timing and arithmetic.
module tb_vertex_transform;
  import vertex_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vertex_transform_if bus ();

  vertex_transform dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int    due;
    vec4_t v1;
    vec4_t v2;
    vec4_t v3;
    logic  done;
  } exp_t;

  exp_t exp_q[$];

  int    n_checks = 0;
  int    n_fail   = 0;
  bit    mon_en   = 1'b0;
  vec4_t last1 = '0, last2 = '0, last3 = '0;

  // reference model state
  int m_act[16];
  int m_shd[16];
  bit m_pend = 1'b0;
  bit m_part = 1'b0;
  bit m_ovf  = 1'b0;
  int m_last_acc = -100;

  function automatic void chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
    end
  endfunction

  function automatic vec4_t model_xform(input int m[16], input vec4_t v);
    vec4_t res;
    int comp[4];
    logic signed [127:0] acc, q;
    comp[0] = v[3];
    comp[1] = v[2];
    comp[2] = v[1];
    comp[3] = FIXED_ONE;
    for (int r = 0; r < 4; r++) begin
      acc = '0;
      for (int c = 0; c < 4; c++) acc = acc + 128'(m[r*4+c]) * 128'(comp[c]);
      q = acc >>> FRAC_BITS;
      if (q > 128'sh7FFF_FFFF)        res[3-r] = 32'h7FFF_FFFF;
      else if (q < -128'sh8000_0000)  res[3-r] = 32'h8000_0000;
      else                            res[3-r] = q[31:0];
    end
    return res;
  endfunction

  function automatic vec4_t mk(input int x, input int y, input int z, input int w);
    vec4_t v;
    v[3] = x; v[2] = y; v[1] = z; v[0] = w;
    return v;
  endfunction

  function automatic int rand_comp();
    int s;
    if ($urandom_range(0, 7) == 0) return $urandom;
    s = int'($urandom_range(0, 32'h0020_0000));
    return s - 1048576;
  endfunction

  function automatic vec4_t rand_vec();
    return mk(rand_comp(), rand_comp(), rand_comp(), rand_comp());
  endfunction

  function automatic int rand_mat();
    int s;
    s = int'($urandom_range(0, 32'h0008_0000));
    return s - 262144;
  endfunction

  // One clock: evaluate the model on the inputs currently driven, then advance.
  task automatic step();
    int   n_act[16];
    int   n_shd[16];
    bit   n_pend, n_part, n_ovf, busy, pbusy, copy, acc, was_rst;
    int   n_last, k;
    exp_t e;
    k = cyc;
    n_act = m_act; n_shd = m_shd;
    n_pend = m_pend; n_part = m_part; n_ovf = m_ovf; n_last = m_last_acc;
    acc = 1'b0;
    was_rst = rst;
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        n_act[i] = (i % 5 == 0) ? FIXED_ONE : 0;
        n_shd[i] = n_act[i];
      end
      n_pend = 1'b0; n_part = 1'b0; n_ovf = 1'b0; n_last = -100;
    end else begin
      busy  = (k - m_last_acc) < 4;
      pbusy = (k - m_last_acc) < 7;
      if (bus.mat_we) n_shd[bus.mat_addr] = bus.mat_data;
      copy = m_pend && !pbusy && !m_part;
      if (copy) n_act = n_shd;
      n_pend = bus.mat_commit ? 1'b1 : (copy ? 1'b0 : m_pend);
      if (bus.valid_in && busy) n_ovf = 1'b1;
      acc = bus.valid_in && !busy;
      if (acc) begin
        n_last = k;
        n_part = !bus.obj_done_in;
        e.due  = k + 6;
        e.v1   = model_xform(n_act, bus.v1_in);
        e.v2   = model_xform(n_act, bus.v2_in);
        e.v3   = model_xform(n_act, bus.v3_in);
        e.done = bus.obj_done_in;
      end
    end
    @(posedge clk);
    #1;
    m_act = n_act; m_shd = n_shd;
    m_pend = n_pend; m_part = n_part; m_ovf = n_ovf; m_last_acc = n_last;
    if (was_rst) begin
      exp_q.delete();
      last1 = '0; last2 = '0; last3 = '0;
    end
    if (acc) exp_q.push_back(e);
    bus.valid_in   = 1'b0;
    bus.mat_we     = 1'b0;
    bus.mat_commit = 1'b0;
    rst            = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic send(input vec4_t a, input vec4_t b, input vec4_t c, input bit done);
    bus.valid_in    = 1'b1;
    bus.v1_in       = a;
    bus.v2_in       = b;
    bus.v3_in       = c;
    bus.obj_done_in = done;
    step();
  endtask

  task automatic wr(input int addr, input int data);
    bus.mat_we   = 1'b1;
    bus.mat_addr = 4'(addr);
    bus.mat_data = data;
    step();
  endtask

  task automatic commit();
    bus.mat_commit = 1'b1;
    step();
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a triangle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (bus.valid_out) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_valid_out: got valid_out=1 expected none (cycle %0d)", cyc);
          end else begin
            e = exp_q.pop_front();
            chk("latency_cycle", 128'(cyc), 128'(e.due));
            chk("v1_out", bus.v1_out, e.v1);
            chk("v2_out", bus.v2_out, e.v2);
            chk("v3_out", bus.v3_out, e.v3);
            chk("obj_done_out", 128'(bus.obj_done_out), 128'(e.done));
            last1 = e.v1; last2 = e.v2; last3 = e.v3;
          end
        end else begin
          chk("hold_v1", bus.v1_out, last1);
          chk("hold_v2", bus.v2_out, last2);
          chk("hold_v3", bus.v3_out, last3);
          chk("obj_done_idle", 128'(bus.obj_done_out), 128'(1'b0));
        end
        if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
          e = exp_q.pop_front();
          n_checks++;
          n_fail++;
          $display("FAIL missing_valid_out: got none expected triangle due at cycle %0d (cycle %0d)", e.due, cyc);
        end
        chk("mat_pending", 128'(bus.mat_pending), 128'(m_pend));
        chk("overflow", 128'(bus.overflow), 128'(m_ovf));
        chk("fsm_idle", 128'(bus.dbg_state == ST_IDLE), 128'((cyc - m_last_acc) >= 4));
      end
    end
  end

  initial begin
    bus.v1_in = '0; bus.v2_in = '0; bus.v3_in = '0;
    bus.valid_in = 1'b0; bus.obj_done_in = 1'b0;
    bus.mat_we = 1'b0; bus.mat_addr = '0; bus.mat_data = '0; bus.mat_commit = 1'b0;
    for (int i = 0; i < 16; i++) begin
      m_act[i] = (i % 5 == 0) ? FIXED_ONE : 0;
      m_shd[i] = m_act[i];
    end

    rst = 1'b1; step();
    rst = 1'b1; step();
    mon_en = 1'b1;
    idle(2);

    // identity after reset
    send(mk(32'h1_0000, 32'h2_0000, 32'h3_0000, 32'h1_0000), rand_vec(), rand_vec(), 1'b1);
    idle(8);

    // scale by 2.0
    for (int i = 0; i < 4; i++) wr(i*5, 32'h2_0000);
    commit();
    idle(3);
    send(mk(32'h1_8000, 32'h1_0000, -32'sh8000, 32'h7), rand_vec(), rand_vec(), 1'b1);
    idle(8);

    // translation column
    wr(3, 32'h5_0000);
    commit();
    idle(2);
    send(mk(32'h1_0000, 32'h4_0000, 32'h2_0000, 0), rand_vec(), rand_vec(), 1'b1);
    idle(8);

    // saturation both ways
    for (int i = 0; i < 4; i++) wr(i*5, 32'h7FFF_0000);
    wr(3, 0);
    commit();
    idle(2);
    send(mk(32'h7FFF_0000, 32'h8000_0000, 32'h1_0000, 0),
         mk(32'h8000_0000, 32'h7FFF_0000, -32'sh1_0000, 0), rand_vec(), 1'b1);
    idle(8);

    // commit in the middle of an object
    for (int i = 0; i < 4; i++) wr(i*5, 32'h1_0000);
    commit();
    idle(2);
    send(rand_vec(), rand_vec(), rand_vec(), 1'b0);
    idle(2);
    wr(0, 32'h3_0000);
    commit();
    idle(2);
    send(rand_vec(), rand_vec(), rand_vec(), 1'b1);
    idle(10);
    send(mk(32'h1_0000, 32'h1_0000, 32'h1_0000, 0), rand_vec(), rand_vec(), 1'b1);
    idle(8);

    // back-to-back drop, then spaced triangles
    send(rand_vec(), rand_vec(), rand_vec(), 1'b0);
    idle(1);
    send(rand_vec(), rand_vec(), rand_vec(), 1'b1);
    idle(8);
    send(rand_vec(), rand_vec(), rand_vec(), 1'b0);
    idle(6);
    send(rand_vec(), rand_vec(), rand_vec(), 1'b0);
    idle(6);
    send(rand_vec(), rand_vec(), rand_vec(), 1'b1);
    idle(8);

    // reset three cycles after an accept, with a commit waiting
    wr(5, 32'h4_0000);
    commit();
    send(rand_vec(), rand_vec(), rand_vec(), 1'b1);
    idle(2);
    rst = 1'b1; step();
    idle(10);
    send(mk(32'h2_0000, 32'h3_0000, 32'h4_0000, 0), rand_vec(), rand_vec(), 1'b1);
    idle(8);

    // random traffic
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        bus.mat_we   = 1'b1;
        bus.mat_addr = 4'($urandom_range(0, 15));
        bus.mat_data = rand_mat();
      end
      if ($urandom_range(0, 11) == 0) bus.mat_commit = 1'b1;
      if ($urandom_range(0, 2) == 0) begin
        bus.valid_in    = 1'b1;
        bus.v1_in       = rand_vec();
        bus.v2_in       = rand_vec();
        bus.v3_in       = rand_vec();
        bus.obj_done_in = ($urandom_range(0, 2) == 0);
      end
      step();
    end

    idle(12);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d triangles outstanding expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vertex_transform.md
Name: vertex_transform

Overview:
- Downstream of the vertex-fetch stage. Captures one triangle per input pulse: three homogeneous vertices plus an end-of-object flag.
- Multiplies each vertex by a 4x4 signed fixed-point model-view-projection matrix and emits the transformed triangle with a single-cycle valid pulse.
- Uses a shared 3-stage matrix-vector pipeline, fed one vertex per cycle.
- Matrix is double-buffered and loaded through a write port; the new matrix only takes effect at object boundaries.

Parameters:
- FRAC_BITS, 16, fractional bits of the signed fixed-point format (Q16.16) used for vertices and matrix entries.
- PIPE_LAT, 3, matrix-vector pipeline depth in cycles; fixed and not overridable in this revision.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  synchronous active-high reset.
- v1_in  input  32x[3:0]  vertex 1: [3]=x, [2]=y, [1]=z, [0]=w; w is ignored.
- v2_in  input  32x[3:0]  vertex 2, same layout.
- v3_in  input  32x[3:0]  vertex 3, same layout.
- valid_in  input  1  single-cycle pulse; all v*_in are valid this cycle.
- obj_done_in  input  1  qualified by valid_in; this is the object's last triangle.
- mat_we  input  1  write one shadow matrix entry.
- mat_addr  input  4  entry index, row*4+col; row 0 produces x.
- mat_data  input  32  signed Q16.16 entry.
- mat_commit  input  1  request shadow->active copy.
- v1_out  output  32x[3:0]  transformed vertex 1: [3]=x', [2]=y', [1]=z', [0]=w'.
- v2_out  output  32x[3:0]  transformed vertex 2, same layout.
- v3_out  output  32x[3:0]  transformed vertex 3, same layout.
- valid_out  output  1  single-cycle pulse; all v*_out are valid this cycle.
- obj_done_out  output  1  high with valid_out for the last triangle of an object.
- mat_pending  output  1  commit requested but not yet applied.
- overflow  output  1  sticky; a triangle was dropped because the block was busy.

Behaviour:
- Reset values:
  - All outputs 0; v*_out all 0.
  - Active and shadow matrices = identity (diagonal 0x0001_0000, others 0).
  - FSM in IDLE.
- Reset mid-operation:
  - Discards any captured or in-flight triangle and any pending commit.
  - Restores the identity matrix.
  - valid_out does not pulse for anything accepted before reset.
- FSM states IDLE, ISSUE1, ISSUE2, ISSUE3.
  - IDLE & valid_in: capture v1..v3 and obj_done_in, go to ISSUE1.
  - ISSUEk drives captured vertex k into the pipeline and advances; ISSUE3 -> IDLE.
- Accept rate:
  - One triangle per 4 cycles (accept, then 3 issue cycles).
  - valid_in while not IDLE: triangle dropped, overflow set (sticky until reset).
- Input w is ignored; the pipeline uses w = 1.0 (0x0001_0000).
- Pipeline arithmetic:
  - Stage 1 registers 16 signed 32x32 -> 64-bit products.
  - Stage 2 registers 4 row sums, 66-bit sign-extended.
  - Stage 3 arithmetic-shifts right FRAC_BITS (truncate toward -inf) and saturates to signed 32-bit (0x7FFF_FFFF / 0x8000_0000).
- Latency:
  - valid_in sampled high in cycle t -> valid_out high in cycle t+6 exactly.
  - v*_out hold their values until the next valid_out.
- obj_done_out travels alongside its triangle and pulses only with valid_out.
- Matrix write:
  - mat_we writes the shadow entry on the clock edge.
  - Writes never affect the active matrix directly.
- Matrix commit:
  - mat_commit sets mat_pending.
  - The copy happens on the first cycle where all of the following hold: FSM IDLE, pipeline empty, no partially processed object.
  - "Partially processed object": a triangle was accepted since the last accepted obj_done_in.
  - mat_pending clears on the copy cycle.
  - Commit in the same cycle as mat_we: the copy takes the written value.
  - A triangle accepted in the same cycle that a commit becomes eligible uses the new matrix, and the commit wins.
- Triangles of one object always use a single matrix.

Decomposition:
- Package vertex_pkg:
  - typedef fixed_t (signed 32-bit) and vec4_t (fixed_t [3:0]).
  - Constants FRAC_BITS, FIXED_ONE = 32'h0001_0000, identity-matrix constant.
  - Saturation function.
- Sub-module mat_vec_pipe:
  - 4x4 matrix times vec4, 3 registered stages, valid in/out plus a 2-bit vertex tag.
  - vertex_transform holds the FSM, capture registers, matrix banks and output assembly.

Test Plan:
- Identity after reset; valid_in with v1=(0x10000, 0x20000, 0x30000, w=1) -> cycle t+6 v1_out=(0x10000, 0x20000, 0x30000, 0x10000), valid_out exactly 1 cycle.
- Write diag = 0x20000 (2.0), commit while IDLE -> mat_pending clears next cycle; v=(0x18000, ...) -> x'=0x30000; entry [0][3]=0x50000 gives x'=x+5.0.
- Saturation: diag=0x7FFF_0000, v x=0x7FFF_0000 -> x'=0x7FFF_FFFF; x=0x8000_0000 -> x'=0x8000_0000.
- Commit mid-object: 2 triangles, first with obj_done_in=0, commit between them -> second uses old matrix, mat_pending held until after the obj_done triangle, then applied.
- Back-to-back valid_in 2 cycles apart -> second dropped, overflow=1, only one valid_out; triangles spaced 7 cycles -> all delivered, obj_done_out on the last.
- rst_in asserted at t+3 of an accepted triangle -> no valid_out afterwards, outputs 0, matrix identity.
